// File: rtl/alu_writeback_unit.sv
// ALU output consumer: writeback FIFO, NZCV flag register
// and single-cycle branch-condition evaluation.
module alu_writeback_unit #(
  parameter int DEPTH  = 2,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_result,
  input  logic              in_carry,
  input  logic              in_zero,
  input  logic              in_negative,
  input  logic              in_overflow,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              in_set_flags,
  input  logic              in_no_wb,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [31:0]       wb_data,
  output logic [REG_AW-1:0] wb_rd,
  output logic [3:0]        flags,
  input  logic              cond_req,
  input  logic [2:0]        cond_code,
  output logic              cond_ack,
  output logic              cond_taken
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [31:0]       data_mem [DEPTH];
  logic [REG_AW-1:0] rd_mem   [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count;

  logic       accept;
  logic       push;
  logic       pop;
  logic [3:0] flags_fwd;
  logic       eval;

  // in_ready depends only on the stored count, never on in_valid/wb_ready.
  assign in_ready = (count < FULL);
  assign wb_valid = (count != '0);
  assign wb_data  = data_mem[rd_ptr];
  assign wb_rd    = rd_mem[rd_ptr];

  assign accept = in_valid && in_ready;
  assign push   = accept && !in_no_wb && (in_rd != '0);
  assign pop    = wb_valid && wb_ready;

  // Forward a same-cycle flag update into the condition evaluation.
  always_comb begin
    flags_fwd = flags;
    if (accept && in_set_flags)
      flags_fwd = {in_negative, in_zero, in_carry, in_overflow};
  end

  // Decode the condition selector against the forwarded NZCV.
  always_comb begin
    eval = 1'b0;
    unique case (cond_code)
      3'b000: eval = flags_fwd[2];
      3'b001: eval = !flags_fwd[2];
      3'b010: eval = flags_fwd[3] ^ flags_fwd[0];
      3'b011: eval = !(flags_fwd[3] ^ flags_fwd[0]);
      3'b100: eval = flags_fwd[1];
      3'b101: eval = !flags_fwd[1];
      3'b110: eval = 1'b1;
      3'b111: eval = 1'b0;
      default: eval = 1'b0;
    endcase
  end

  // FIFO storage; cleared on reset so an empty head reads as zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_mem[i] <= '0;
        rd_mem[i]   <= '0;
      end
    end else if (push) begin
      data_mem[wr_ptr] <= in_result;
      rd_mem[wr_ptr]   <= in_rd;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Architectural NZCV register.
  always_ff @(posedge clk) begin
    if (reset)
      flags <= 4'b0000;
    else if (accept && in_set_flags)
      flags <= {in_negative, in_zero, in_carry, in_overflow};
  end

  // One-cycle query response; taken holds between acks.
  always_ff @(posedge clk) begin
    if (reset) begin
      cond_ack   <= 1'b0;
      cond_taken <= 1'b0;
    end else begin
      cond_ack <= cond_req;
      if (cond_req) cond_taken <= eval;
    end
  end

endmodule

// File: tb/tb_alu_writeback_unit.sv
// Directed bench for alu_writeback_unit with a queue-based
// reference model checked on every falling edge.
module tb_alu_writeback_unit;

  localparam int DEPTH  = 2;
  localparam int REG_AW = 5;

  logic              clk = 0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_result;
  logic              in_carry, in_zero, in_negative, in_overflow;
  logic [REG_AW-1:0] in_rd;
  logic              in_set_flags, in_no_wb;
  logic              wb_valid, wb_ready;
  logic [31:0]       wb_data;
  logic [REG_AW-1:0] wb_rd;
  logic [3:0]        flags;
  logic              cond_req;
  logic [2:0]        cond_code;
  logic              cond_ack, cond_taken;

  alu_writeback_unit #(.DEPTH(DEPTH), .REG_AW(REG_AW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_carry(in_carry),
    .in_zero(in_zero), .in_negative(in_negative),
    .in_overflow(in_overflow), .in_rd(in_rd),
    .in_set_flags(in_set_flags), .in_no_wb(in_no_wb),
    .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_data(wb_data), .wb_rd(wb_rd), .flags(flags),
    .cond_req(cond_req), .cond_code(cond_code),
    .cond_ack(cond_ack), .cond_taken(cond_taken)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of pending writes plus NZCV bits.
  typedef struct { logic [REG_AW-1:0] rd; logic [31:0] d; } ent_t;
  ent_t q[$];
  bit   mN, mZ, mC, mV;
  bit   m_ack, m_taken;

  function automatic bit cond_of(input logic [2:0] c);
    case (c)
      3'd0: return mZ;
      3'd1: return !mZ;
      3'd2: return mN != mV;
      3'd3: return mN == mV;
      3'd4: return mC;
      3'd5: return !mC;
      3'd6: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  always @(posedge clk) begin
    bit acc, pop_now;
    if (reset) begin
      q.delete();
      {mN, mZ, mC, mV} = '0;
      m_ack = 0;
      m_taken = 0;
    end else begin
      acc = in_valid && (q.size() < DEPTH);
      pop_now = wb_ready && (q.size() != 0);
      if (pop_now) void'(q.pop_front());
      if (acc && !in_no_wb && in_rd != 0)
        q.push_back('{rd: in_rd, d: in_result});
      if (acc && in_set_flags) begin
        mN = in_negative; mZ = in_zero;
        mC = in_carry;    mV = in_overflow;
      end
      m_ack = cond_req;
      if (cond_req) m_taken = cond_of(cond_code);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", in_ready, q.size() < DEPTH);
      chk("wb_valid", wb_valid, q.size() != 0);
      if (q.size() != 0) begin
        chk("wb_data", wb_data, q[0].d);
        chk("wb_rd", wb_rd, q[0].rd);
      end
      chk("flags", flags, {mN, mZ, mC, mV});
      chk("cond_ack", cond_ack, m_ack);
      chk("cond_taken", cond_taken, m_taken);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic alu(input logic [31:0] r, input logic [4:0] rd,
                     input logic n, z, c, v, sf, nowb);
    in_valid = 1; in_result = r; in_rd = rd;
    in_negative = n; in_zero = z; in_carry = c; in_overflow = v;
    in_set_flags = sf; in_no_wb = nowb;
  endtask

  logic [2:0] cc;

  initial begin
    reset = 1; in_valid = 0; in_result = 0; in_rd = 0;
    {in_carry, in_zero, in_negative, in_overflow} = '0;
    in_set_flags = 0; in_no_wb = 0; wb_ready = 0;
    cond_req = 0; cond_code = 0;
    step(); step();
    reset = 0;
    chk_en = 1;
    chk("rst in_ready", in_ready, 1);
    chk("rst wb_valid", wb_valid, 0);
    chk("rst wb_data", wb_data, 0);
    chk("rst flags", flags, 4'b0000);
    chk("rst cond_ack", cond_ack, 0);

    alu(25, 3, 0, 0, 0, 0, 1, 0);
    step();
    in_valid = 0;
    chk("add wb_valid", wb_valid, 1);
    chk("add wb_data", wb_data, 25);
    chk("add wb_rd", wb_rd, 3);
    chk("add flags", flags, 4'b0000);

    wb_ready = 1;
    step();
    wb_ready = 0;
    chk("pop25 wb_valid", wb_valid, 0);

    alu(10, 4, 0, 0, 0, 0, 0, 0);
    step();
    alu(4, 5, 0, 0, 0, 0, 0, 0);
    step();
    chk("full in_ready", in_ready, 0);
    alu(99, 6, 0, 0, 0, 0, 0, 0);
    step();
    in_valid = 0;
    chk("blocked head", wb_data, 10);
    wb_ready = 1;
    step();
    chk("pop1 in_ready", in_ready, 1);
    chk("pop1 head", wb_data, 4);
    chk("pop1 rd", wb_rd, 5);
    step();
    wb_ready = 0;
    chk("drained", wb_valid, 0);

    alu(32'hFFFF_FFF6, 9, 1, 0, 1, 0, 1, 1);
    step();
    in_valid = 0;
    chk("cmp flags", flags, 4'b1010);
    chk("cmp nopush", wb_valid, 0);
    cond_req = 1; cond_code = 3'b010;
    step();
    chk("LT ack", cond_ack, 1);
    chk("LT taken", cond_taken, 1);
    cond_code = 3'b100;
    step();
    chk("LTU ack", cond_ack, 1);
    chk("LTU taken", cond_taken, 1);
    cond_code = 3'b011;
    step();
    chk("GE ack", cond_ack, 1);
    chk("GE taken", cond_taken, 0);
    cond_req = 0;
    step();
    chk("idle ack", cond_ack, 0);
    chk("hold taken", cond_taken, 0);

    alu(0, 0, 0, 1, 0, 0, 1, 1);
    cond_req = 1; cond_code = 3'b000;
    step();
    in_valid = 0; cond_req = 0;
    chk("fwd ack", cond_ack, 1);
    chk("fwd EQ", cond_taken, 1);
    chk("fwd flags", flags, 4'b0100);

    for (int i = 0; i < 8; i++) begin
      cc = 3'(i);
      cond_req = 1; cond_code = cc;
      step();
    end
    cond_req = 0;

    alu(32'h8000_0000, 0, 1, 0, 0, 0, 1, 0);
    step();
    in_valid = 0;
    chk("r0 nopush", wb_valid, 0);
    chk("r0 flags", flags, 4'b1000);

    alu(7, 7, 0, 1, 1, 1, 0, 0);
    step();
    chk("noset flags", flags, 4'b1000);
    alu(8, 8, 0, 0, 0, 0, 0, 0);
    wb_ready = 1;
    step();
    in_valid = 0; wb_ready = 0;
    chk("pp head", wb_data, 8);

    alu(9, 9, 0, 0, 0, 0, 0, 0);
    step();
    in_valid = 0;
    chk("fill in_ready", in_ready, 0);
    reset = 1; cond_req = 1; cond_code = 3'b110;
    step();
    reset = 0; cond_req = 0;
    chk("rst2 wb_valid", wb_valid, 0);
    chk("rst2 flags", flags, 4'b0000);
    chk("rst2 cond_ack", cond_ack, 0);
    chk("rst2 in_ready", in_ready, 1);
    step(); step();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_writeback_unit.md
Name: alu_writeback_unit

Overview:
- Consumer side of the ALU output interface: accepts each ALU result and flag set (result, carry, zero, negative, overflow) through a valid/ready handshake.
- Buffers results in a small FIFO for the register-file write port.
- Maintains the architectural NZCV flag register.
- Answers branch-condition queries against those flags.
- Sits between the ALU and the register file / branch logic in the execute-writeback path.

Parameters:
- DEPTH, 2, writeback FIFO entries (power of two, 2..8).
- REG_AW, 5, destination register index width.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous active-high reset.
- in_valid  input  1  ALU output valid.
- in_ready  output  1  unit can accept this cycle.
- in_result  input  32  ALU result.
- in_carry  input  1  ALU carry (borrow for SUB).
- in_zero  input  1  ALU zero flag.
- in_negative  input  1  ALU negative flag.
- in_overflow  input  1  ALU overflow flag.
- in_rd  input  REG_AW  destination register.
- in_set_flags  input  1  update NZCV on accept.
- in_no_wb  input  1  compare-type op; no register write.
- wb_valid  output  1  FIFO head valid.
- wb_ready  input  1  register file consumes head.
- wb_data  output  32  head result.
- wb_rd  output  REG_AW  head destination.
- flags  output  4  NZCV register {N,Z,C,V}.
- cond_req  input  1  condition query strobe.
- cond_code  input  3  condition selector.
- cond_ack  output  1  query answered.
- cond_taken  output  1  query result.

Behaviour:
- Single clock domain; reset is synchronous and active-high (clk, reset).
- Reset values:
  - FIFO count = 0; read and write pointers = 0.
  - wb_valid = 0; wb_data = 0; wb_rd = 0.
  - flags = 4'b0000.
  - cond_ack = 0; cond_taken = 0.
- Reset mid-operation discards all FIFO entries and any pending query.
- Accept: occurs when in_valid && in_ready.
  - in_ready = (count < DEPTH), registered from state only; it has no combinational path from in_valid or wb_ready.
- Push: on accept, an entry is pushed iff in_no_wb == 0 and in_rd != 0.
  - Writes to register 0 and compare-type ops are dropped silently but still accepted; they may update flags.
- Pop: occurs when wb_valid && wb_ready. wb_valid = (count != 0). wb_data/wb_rd show the head entry, driven from FIFO storage.
- Simultaneous push and pop: count is unchanged; both pointers advance.
  - Push while full cannot occur, because in_ready is low.
  - A pop at count 1 with a simultaneous push delivers the new entry next cycle; there is no fall-through in the same cycle.
- Pointers wrap modulo DEPTH.
- FIFO order is strictly in-order; data is unchanged from input.
- Flags: on accept with in_set_flags = 1, flags <= {in_negative, in_zero, in_carry, in_overflow} at that edge. Otherwise flags are held.
- Condition query: latency 1.
  - cond_req at cycle t produces cond_ack = 1 at t+1 for exactly one cycle; cond_ack = 0 otherwise.
  - cond_taken is evaluated on the forwarded flags. If a flag-setting accept occurs in the same cycle as cond_req, the new flags are used; otherwise the current flags.
  - Back-to-back requests give back-to-back acks.
- cond_code encoding:
  - 000 EQ: Z
  - 001 NE: !Z
  - 010 LT: N^V
  - 011 GE: !(N^V)
  - 100 LTU: C (the ALU carry after SUB is the borrow)
  - 101 GEU: !C
  - 110 AL: 1
  - 111 NV: 0
- cond_taken holds its last value when cond_ack = 0.

Test Plan:
- Reset, then accept ADD result 25 (in_carry=0, in_zero=0, rd=3, in_set_flags=1) with wb_ready=0 -> next cycle wb_valid=1, wb_data=25, wb_rd=3, flags=4'b0000.
- Keep wb_ready=0 and accept 2 results (10 to rd 4, 4 to rd 5) -> after 2 accepts in_ready=0, a third in_valid is not accepted. Raise wb_ready -> pops in order 10, then 4; in_ready returns to 1 the cycle after the first pop.
- Compare 10-20 (result 0xFFFFFFF6, N=1, C=1, V=0, in_no_wb=1, in_set_flags=1) -> no FIFO push, flags=4'b1010. Queries LT, LTU, GE next cycle -> cond_taken 1, 1, 0, each with a 1-cycle ack.
- Same-cycle compare 5-5 (Z=1, in_set_flags=1) and cond_req EQ -> cond_ack=1 and cond_taken=1 next cycle (forwarded flags).
- Accept with in_rd=0 and in_no_wb=0 -> no push, wb_valid stays 0. Flags still update if in_set_flags=1.
- Fill the FIFO, then pulse reset for 1 cycle with cond_req high -> wb_valid=0, flags=0, cond_ack=0 on the following cycle, in_ready=1.
